// File: rtl/rca_wb_sequencer_pkg.sv
// rtl/rca_wb_sequencer_pkg.sv - shared RCA writeback types and helpers
package rca_wb_sequencer_pkg;
    localparam int NUM_WRITE_PORTS = 5;
    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int ID_W            = 4;
    localparam int IDX_W           = $clog2(NUM_WRITE_PORTS);

    typedef logic [ID_W-1:0]  id_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } seq_state_t;

    typedef struct packed {
        id_t                                         id;
        logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]        rd;
        logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0]  addr;
        logic [NUM_WRITE_PORTS-1:0]                  mask;
    } rca_wb_bundle_t;

    // Writes aimed at x0 are architecturally void, so they never become beats.
    function automatic logic [NUM_WRITE_PORTS-1:0] x0_filter(
        input logic [NUM_WRITE_PORTS-1:0]                 mask,
        input logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] addr
    );
        logic [NUM_WRITE_PORTS-1:0] f;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            f[i] = mask[i] && (addr[i] != '0);
        end
        return f;
    endfunction
endpackage

// File: rtl/rca_wb_sequencer_if.sv
// rtl/rca_wb_sequencer_if.sv - grid bundle input and regfile beat output bus
interface rca_wb_sequencer_if;
    import rca_wb_sequencer_pkg::*;

    logic                                        flush;
    logic                                        bundle_valid;
    logic                                        bundle_ready;
    id_t                                         bundle_id;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]        bundle_rd;
    logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0]  bundle_rd_addr;
    logic [NUM_WRITE_PORTS-1:0]                  bundle_wr_mask;
    logic                                        wb_valid;
    logic                                        wb_ready;
    logic                                        wb_we;
    logic [REG_ADDR_W-1:0]                       wb_rd_addr;
    logic [XLEN-1:0]                             wb_data;
    id_t                                         wb_id;
    logic                                        wb_last;
    logic                                        busy;

    modport master (
        output flush, bundle_valid, bundle_id, bundle_rd, bundle_rd_addr, bundle_wr_mask, wb_ready,
        input  bundle_ready, wb_valid, wb_we, wb_rd_addr, wb_data, wb_id, wb_last, busy
    );

    modport slave (
        input  flush, bundle_valid, bundle_id, bundle_rd, bundle_rd_addr, bundle_wr_mask, wb_ready,
        output bundle_ready, wb_valid, wb_we, wb_rd_addr, wb_data, wb_id, wb_last, busy
    );
endinterface

// File: rtl/rca_wb_sequencer_lowest_set_idx.sv
// rtl/rca_wb_sequencer_lowest_set_idx.sv - lowest set bit index, mask with it cleared, single-bit flag
module rca_lowest_set_idx
    import rca_wb_sequencer_pkg::*;
(
    input  logic [NUM_WRITE_PORTS-1:0] mask,
    output idx_t                       idx,
    output logic [NUM_WRITE_PORTS-1:0] rest,
    output logic                       is_last
);
    always_comb begin
        idx = '0;
        for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = idx_t'(i);
            end
        end
    end

    assign rest    = mask & (mask - NUM_WRITE_PORTS'(1));
    assign is_last = (mask != '0) && (rest == '0);
endmodule

// File: rtl/rca_wb_sequencer.sv
// rtl/rca_wb_sequencer.sv - serializes an RCA result bundle onto the single regfile write port
module rca_wb_sequencer
    import rca_wb_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rca_wb_sequencer_if.slave bus
);
    seq_state_t                 state;
    rca_wb_bundle_t             cur;
    rca_wb_bundle_t             in_bundle;
    rca_wb_bundle_t             sel;
    logic                       beat_done;
    logic                       accept;
    logic [NUM_WRITE_PORTS-1:0] pend_rest;
    idx_t                       sel_idx;
    logic                       sel_last;
    idx_t                       unused_pend_idx;
    logic                       unused_pend_last;
    logic [NUM_WRITE_PORTS-1:0] unused_sel_rest;

    assign beat_done        = bus.wb_valid && bus.wb_ready;
    assign bus.bundle_ready = !bus.flush && (state == ST_IDLE || (beat_done && bus.wb_last));
    assign accept           = bus.bundle_valid && bus.bundle_ready;
    assign bus.busy         = (state != ST_IDLE);

    always_comb begin
        in_bundle.id   = bus.bundle_id;
        in_bundle.rd   = bus.bundle_rd;
        in_bundle.addr = bus.bundle_rd_addr;
        in_bundle.mask = x0_filter(bus.bundle_wr_mask, bus.bundle_rd_addr);
    end

    // cur.mask is the pending mask and still includes the beat on the wb_* outputs.
    rca_lowest_set_idx u_pend (
        .mask    (cur.mask),
        .idx     (unused_pend_idx),
        .rest    (pend_rest),
        .is_last (unused_pend_last)
    );

    // Source of the next beat: a freshly accepted bundle, or the remainder of the current one.
    always_comb begin
        sel      = cur;
        sel.mask = pend_rest;
        if (accept) begin
            sel = in_bundle;
        end
    end

    rca_lowest_set_idx u_next (
        .mask    (sel.mask),
        .idx     (sel_idx),
        .rest    (unused_sel_rest),
        .is_last (sel_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cur            <= '0;
            bus.wb_valid   <= 1'b0;
            bus.wb_we      <= 1'b0;
            bus.wb_last    <= 1'b0;
            bus.wb_data    <= '0;
            bus.wb_rd_addr <= '0;
            bus.wb_id      <= '0;
        end else if (bus.flush) begin
            state        <= ST_IDLE;
            cur.mask     <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_we    <= 1'b0;
            bus.wb_last  <= 1'b0;
        end else if (accept || (beat_done && !bus.wb_last)) begin
            // An empty bundle still produces one id-only beat so the id retires.
            state          <= ST_DRAIN;
            cur            <= sel;
            bus.wb_valid   <= 1'b1;
            bus.wb_we      <= (sel.mask != '0);
            bus.wb_rd_addr <= sel.addr[sel_idx];
            bus.wb_data    <= sel.rd[sel_idx];
            bus.wb_id      <= sel.id;
            bus.wb_last    <= sel_last || (sel.mask == '0);
        end else if (beat_done) begin
            state        <= ST_IDLE;
            cur.mask     <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_we    <= 1'b0;
            bus.wb_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rca_wb_sequencer.sv
// tb/tb_rca_wb_sequencer.sv - self-checking bench for rca_wb_sequencer
module tb_rca_wb_sequencer;
    import rca_wb_sequencer_pkg::*;

    typedef logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] addr_vec_t;

    typedef struct {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
        id_t                   id;
        logic                  last;
    } beat_t;

    typedef struct {
        logic [NUM_WRITE_PORTS-1:0]       mask;
        addr_vec_t                        addr;
        id_t                              id;
        int                               n;
        addr_vec_t                        exp_addr;
        logic [NUM_WRITE_PORTS-1:0][2:0]  exp_port;
        logic                             exp_we;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    rca_wb_sequencer_if bus ();

    rca_wb_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    beat_t          q[$];
    beat_t          got[$];
    int             total = 0;
    int             bad   = 0;
    rca_wb_bundle_t b, a, bb, b_idle, b_full;
    vec_t           vt[6];
    logic           fl, bv, wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] port_data(input id_t id, input int p);
        return 32'hD000_0000 | (32'(id) << 8) | 32'(p);
    endfunction

    function automatic rca_wb_bundle_t make_bundle(input logic [NUM_WRITE_PORTS-1:0] mask,
                                                   input addr_vec_t addr, input id_t id);
        rca_wb_bundle_t r;
        r.mask = mask;
        r.addr = addr;
        r.id   = id;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) r.rd[p] = port_data(id, p);
        return r;
    endfunction

    // Reference: one beat per real, non-x0 write in ascending port order; else one id-only beat.
    task automatic push_model(input rca_wb_bundle_t r);
        int k = 0;
        int j = 0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) if (r.mask[p] && r.addr[p] != 0) k++;
        if (k == 0) begin
            q.push_back('{we: 1'b0, addr: '0, data: '0, id: r.id, last: 1'b1});
        end else begin
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (r.mask[p] && r.addr[p] != 0) begin
                    j++;
                    q.push_back('{we: 1'b1, addr: r.addr[p], data: r.rd[p], id: r.id, last: (j == k)});
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("wb_valid", bus.wb_valid, q.size() != 0);
        chk("busy", bus.busy, q.size() != 0);
        if (q.size() != 0) begin
            chk("wb_we", bus.wb_we, q[0].we);
            chk("wb_last", bus.wb_last, q[0].last);
            chk("wb_id", bus.wb_id, q[0].id);
            if (q[0].we) begin
                chk("wb_rd_addr", bus.wb_rd_addr, q[0].addr);
                chk("wb_data", bus.wb_data, q[0].data);
            end
        end
    endtask

    task automatic step(input logic f, input logic v, input logic r, input rca_wb_bundle_t x);
        logic exp_ready;
        bus.flush          = f;
        bus.bundle_valid   = v;
        bus.wb_ready       = r;
        bus.bundle_id      = x.id;
        bus.bundle_rd      = x.rd;
        bus.bundle_rd_addr = x.addr;
        bus.bundle_wr_mask = x.mask;
        #1;
        exp_ready = !f && (q.size() == 0 || (r && q.size() == 1));
        chk("bundle_ready", bus.bundle_ready, exp_ready);
        if (f) begin
            q.delete();
        end else begin
            if (r && q.size() != 0) begin
                got.push_back('{we: bus.wb_we, addr: bus.wb_rd_addr, data: bus.wb_data,
                                id: bus.wb_id, last: bus.wb_last});
                void'(q.pop_front());
            end
            if (v && exp_ready) push_model(x);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && q.size() != 0; c++) step(1'b0, 1'b0, 1'b1, b_idle);
        chk("drain_done", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{mask: 5'b11111, addr: {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, id: 4'd1, n: 5,
                  exp_addr: {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, exp_port: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, exp_we: 1'b1};
        vt[1] = '{mask: 5'b10100, addr: {5'd0, 5'd6, 5'd9, 5'd6, 5'd6}, id: 4'd2, n: 1,
                  exp_addr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd9}, exp_port: {3'd0, 3'd0, 3'd0, 3'd0, 3'd2}, exp_we: 1'b1};
        vt[2] = '{mask: 5'b00000, addr: {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, id: 4'd3, n: 1,
                  exp_addr: '0, exp_port: '0, exp_we: 1'b0};
        vt[3] = '{mask: 5'b01001, addr: {5'd1, 5'd7, 5'd2, 5'd3, 5'd7}, id: 4'd6, n: 2,
                  exp_addr: {5'd0, 5'd0, 5'd0, 5'd7, 5'd7}, exp_port: {3'd0, 3'd0, 3'd0, 3'd3, 3'd0}, exp_we: 1'b1};
        vt[4] = '{mask: 5'b00010, addr: {5'd0, 5'd0, 5'd0, 5'd31, 5'd0}, id: 4'd15, n: 1,
                  exp_addr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd31}, exp_port: {3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, exp_we: 1'b1};
        vt[5] = '{mask: 5'b11111, addr: '0, id: 4'd9, n: 1,
                  exp_addr: '0, exp_port: '0, exp_we: 1'b0};

        b_idle = '0;
        b_full = make_bundle(5'b11111, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 4'd4);

        // Reset values
        rst = 1'b1;
        bus.flush = 1'b0; bus.bundle_valid = 1'b0; bus.wb_ready = 1'b0;
        bus.bundle_id = '0; bus.bundle_rd = '0; bus.bundle_rd_addr = '0; bus.bundle_wr_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_we", bus.wb_we, 0);
        chk("rst_wb_last", bus.wb_last, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_wb_rd_addr", bus.wb_rd_addr, 0);
        chk("rst_wb_id", bus.wb_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bundle_ready", bus.bundle_ready, 1);
        rst = 1'b0;

        // Table-driven bundles
        for (int i = 0; i < 6; i++) begin
            got.delete();
            b = make_bundle(vt[i].mask, vt[i].addr, vt[i].id);
            step(1'b0, 1'b1, 1'b1, b);
            drain();
            chk("tbl_beat_count", got.size(), vt[i].n);
            for (int k = 0; k < got.size() && k < vt[i].n; k++) begin
                chk("tbl_we", got[k].we, vt[i].exp_we);
                chk("tbl_last", got[k].last, k == vt[i].n - 1);
                chk("tbl_id", got[k].id, vt[i].id);
                if (vt[i].exp_we) begin
                    chk("tbl_addr", got[k].addr, vt[i].exp_addr[k]);
                    chk("tbl_data", got[k].data, port_data(vt[i].id, vt[i].exp_port[k]));
                end
            end
        end

        // Stall on beat 2 for three cycles
        got.delete();
        b = make_bundle(5'b01111, {5'd0, 5'd13, 5'd12, 5'd11, 5'd10}, 4'd2);
        step(1'b0, 1'b1, 1'b1, b);
        step(1'b0, 1'b0, 1'b1, b_idle);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, b_idle);
            chk("stall_valid", bus.wb_valid, 1);
            chk("stall_addr", bus.wb_rd_addr, 11);
            chk("stall_data", bus.wb_data, port_data(4'd2, 1));
        end
        drain();
        chk("stall_count", got.size(), 4);
        for (int k = 0; k < got.size() && k < 4; k++) chk("stall_order", got[k].addr, 10 + k);

        // Back-to-back: B presented on A's last beat
        a  = make_bundle(5'b00011, {5'd0, 5'd0, 5'd0, 5'd2, 5'd1}, 4'd1);
        bb = make_bundle(5'b00001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd3}, 4'd5);
        step(1'b0, 1'b1, 1'b1, a);
        step(1'b0, 1'b0, 1'b1, b_idle);
        step(1'b0, 1'b1, 1'b1, bb);
        chk("b2b_valid", bus.wb_valid, 1);
        chk("b2b_addr", bus.wb_rd_addr, 3);
        chk("b2b_id", bus.wb_id, 5);
        drain();

        // Flush during beat 2 of 4 with a bundle waiting
        a  = make_bundle(5'b01111, {5'd0, 5'd4, 5'd3, 5'd2, 5'd1}, 4'd7);
        bb = make_bundle(5'b00100, {5'd0, 5'd0, 5'd20, 5'd0, 5'd0}, 4'd8);
        step(1'b0, 1'b1, 1'b1, a);
        step(1'b0, 1'b0, 1'b1, b_idle);
        step(1'b1, 1'b1, 1'b1, bb);
        chk("flush_valid", bus.wb_valid, 0);
        chk("flush_busy", bus.busy, 0);
        step(1'b0, 1'b1, 1'b1, bb);
        chk("post_flush_addr", bus.wb_rd_addr, 20);
        chk("post_flush_id", bus.wb_id, 8);
        drain();

        // Reset asserted mid-drain
        step(1'b0, 1'b1, 1'b1, b_full);
        step(1'b0, 1'b0, 1'b1, b_idle);
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.wb_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", bus.bundle_ready, 1);

        // Randomized traffic against the reference model
        repeat (400) begin
            fl = ($urandom_range(0, 15) == 0);
            bv = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) != 0);
            b.mask = 5'($urandom);
            b.id   = 4'($urandom);
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                b.addr[p] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                b.rd[p]   = $urandom;
            end
            step(fl, bv, wr, b);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
